instr_fetch_ctrl: RTL
=====================

// Module: instr_fetch_ctrl
// PURPOSE
//  Sequences the word-indexed Instruction_Memory. Owns the PC, drives the memory's Read_address,
//  captures the combinational Instruction into a small fetch queue, and hands instructions to
//  decode over a valid/ready handshake. Sits between Instruction_Memory and the decode stage and
//  accepts branch/jump redirects from execute.
// PARAMETERS
//  IMEM_WORDS  32            words in Instruction_Memory; legal word index 0..IMEM_WORDS-1
//  QDEPTH      2             fetch-queue entries, power of 2, >=2
//  RESET_PC    32'h0000_0000 byte PC loaded at reset
// PORTS
//  clk           in   1   single clock, rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  run           in   1   1 = fetch enabled; 0 = no new fetches, queue still drains
//  Read_address  out  32  word index to Instruction_Memory = {2'b00, pc[31:2]}
//  Instruction   in   32  combinational read data for Read_address, same cycle
//  redirect      in   1   1-cycle pulse: flush and restart at redirect_pc
//  redirect_pc   in   32  byte target; bits [1:0] ignored (treated as 00)
//  out_valid     out  1   out_instr/out_pc hold a valid queue head
//  out_ready     in   1   decode accepts head when out_valid & out_ready
//  out_instr     out  32  instruction at queue head
//  out_pc        out  32  byte PC of out_instr
//  halted        out  1   PC word index >= IMEM_WORDS; fetching stopped
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, queue empty, out_valid=0, out_instr=0, out_pc=0, halted=0,
//   state=RUN. Read_address follows pc combinationally (reset value RESET_PC>>2).
//  States: RUN, HALT.
//   RUN : fetch fires when run=1, queue not full (or head popped this cycle), no redirect.
//         On fire: enqueue {Instruction, pc}; pc<=pc+4 (32-bit wrap).
//         If pc[31:2] >= IMEM_WORDS: no enqueue, halted<=1, go HALT.
//   HALT: no fetches, queue drains normally; leave only on redirect.
//  Redirect (highest priority, any state): same edge, queue flushed (out_valid=0 next cycle),
//   the current-cycle fetch is discarded, pc<={redirect_pc[31:2],2'b00}, halted<=0, state<=RUN.
//   A pop coinciding with redirect is still a completed handshake for decode; the flush
//   discards only the remaining entries.
//  Latency: first instruction after reset or redirect appears on out_valid 1 cycle later
//   (pc registered -> Read_address -> Instruction -> queue write at next edge).
//  Queue: circular FIFO with rd/wr pointers and count [clog2(QDEPTH):0].
//   Full: no fetch unless a pop occurs the same cycle (simultaneous push+pop when full is legal;
//   count unchanged). Empty: out_valid=0, out_instr/out_pc hold last value (don't-care).
//   Sustained throughput is 1 instr/cycle with out_ready=1.
//  out_valid/out_instr/out_pc are stable while out_valid=1 & out_ready=0.
//  run=0 mid-stream: pc frozen, queue drains. run 0->1 resumes at the frozen pc.
//  Reset asserted mid-operation clears everything immediately; no partial state survives.
// STRUCTURE
//  Shared package mips_pkg: WORD_W=32, PC_STEP=4, RESET_PC default, fetch-state enum {RUN,HALT}.
//  One sub-module: fetch_queue (param WIDTH=64, DEPTH=QDEPTH; push/pop/flush/full/empty,
//   async active-low reset). PC register, state FSM and fire logic in instr_fetch_ctrl.
// TESTING  (bench uses behavioural IMEM loaded with mem[i]=32'hA000_0000+i)
//  Reset, run=1, out_ready=1 -> out_pc 0,4,8,... out_instr A0000000,A0000001,... one per cycle.
//  out_ready=0 for 5 cycles -> exactly QDEPTH entries queued, pc stalls at 8, head stable;
//   release -> no loss/duplication, order preserved.
//  Run to pc=0x80 (IMEM_WORDS=32) -> last out_pc=0x7C, halted=1, no further out_valid;
//   redirect_pc=0x10 -> halted=0, next out_pc=0x10, instr A0000004.
//  Redirect to 0x23 while queue full and out_ready=1 -> popped head consumed, rest flushed,
//   next out_pc=0x20.
//  Assert reset_n=0 mid-stream asynchronously -> out_valid=0 and Read_address=0 before next edge;
//   release -> fetch restarts at RESET_PC.
//  run toggled 1/0 every cycle with random out_ready -> scoreboard sees strictly sequential PCs.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: word width, PC increment, reset PC and
// the fetch-controller state encoding.
package mips_pkg;

    localparam int          WORD_W       = 32;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage : mips_pkg

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-to-decode valid/ready handshake carrying an instruction and its byte PC.
interface instr_fetch_ctrl_if;
    import mips_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_instr;
    logic [WORD_W-1:0] out_pc;

    // Fetch side produces instructions, decode side applies back-pressure.
    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );

endinterface : instr_fetch_ctrl_if

// File: rtl/fetch_queue.sv
// Small circular FIFO between instruction memory and decode. A push into a
// full queue is accepted only when the head is popped in the same cycle.
// Flush empties the queue in one cycle; stale storage is left in place.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    // Pointer, occupancy and storage update; storage is cleared on reset so the
    // head reads zero until the first instruction lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : fetch_queue

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, addresses the word-indexed
// instruction memory, queues fetched words and hands them to decode.
// Redirects from execute flush the queue and restart fetch at the target.
module instr_fetch_ctrl
    import mips_pkg::*;
#(
    parameter int          IMEM_WORDS = 32,
    parameter int          QDEPTH     = 2,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    output logic [WORD_W-1:0]     Read_address,
    input  logic [WORD_W-1:0]     Instruction,
    input  logic                  redirect,
    input  logic [WORD_W-1:0]     redirect_pc,
    output logic                  halted,
    instr_fetch_ctrl_if.master    dec
);

    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [WORD_W-1:0]   r_pc;
    logic [WORD_W-1:0]   w_pc_nxt;
    logic                r_halted;
    logic                w_halted_nxt;

    logic                w_full;
    logic                w_empty;
    logic                w_valid;
    logic                w_pop;
    logic                w_oob;
    logic                w_try;
    logic                w_fire;
    logic [2*WORD_W-1:0] w_head;
    logic                w_unused_rp_lsb;

    assign Read_address    = {2'b00, r_pc[31:2]};
    assign halted          = r_halted;
    assign w_valid         = ~w_empty;
    assign w_pop           = w_valid & dec.out_ready;
    assign w_oob           = (r_pc[31:2] >= IMEM_LIMIT);
    // A fetch is attempted only while running, enabled and not being redirected;
    // it lands in the queue if there is room now or the head leaves this cycle.
    assign w_try           = (r_state == RUN) & run & ~redirect;
    assign w_fire          = w_try & ~w_oob & (~w_full | w_pop);
    assign w_unused_rp_lsb = ^redirect_pc[1:0];

    assign dec.out_valid   = w_valid;
    assign dec.out_instr   = w_head[2*WORD_W-1:WORD_W];
    assign dec.out_pc      = w_head[WORD_W-1:0];

    // Next PC, halt flag and fetch state; redirect overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_halted_nxt = r_halted;
        if (redirect) begin
            w_pc_nxt     = {redirect_pc[31:2], 2'b00};
            w_halted_nxt = 1'b0;
            w_state_nxt  = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_try && w_oob) begin
                        w_halted_nxt = 1'b1;
                        w_state_nxt  = HALT;
                    end else if (w_fire) begin
                        w_pc_nxt = r_pc + PC_STEP;
                    end
                end
                HALT: begin
                    w_state_nxt = HALT;
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    // PC, halt flag and state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= RUN;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    fetch_queue #(
        .WIDTH (2*WORD_W),
        .DEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_fire),
        .i_data  ({Instruction, r_pc}),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

endmodule : instr_fetch_ctrl
